// File: rtl/arwb_sched_pkg.sv
// rtl/arwb_sched_pkg.sv - widths and helpers shared by the AR writeback scheduler
package arwb_sched_pkg;

    localparam int SIZE_TGT_GP = 3;
    localparam int HBIT_TGT_GP = SIZE_TGT_GP - 1;
    localparam int SIZE_ADDR   = 32;
    localparam int HBIT_ADDR   = SIZE_ADDR - 1;
    localparam int HBIT_AR     = (1 << SIZE_TGT_GP) - 1;
    localparam int SIZE_AR     = HBIT_AR + 1;

    // One bit per AR, used for both scoreboard set and clear masks.
    function automatic logic [HBIT_AR:0] ar_onehot(input logic [HBIT_TGT_GP:0] ar);
        logic [HBIT_AR:0] m;
        m     = '0;
        m[ar] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/arwb_sched_rr_arb.sv
// rtl/arwb_sched_rr_arb.sv - round-robin arbiter, valid in, one-hot grant out
module arwb_sched_rr_arb #(
    parameter int NREQ = 3
) (
    input  logic            iw_clk,
    input  logic            iw_rst_n,
    input  logic [NREQ-1:0] iw_valid,
    output logic [NREQ-1:0] ow_grant
);

    localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] idx;
    logic [PW-1:0] gnt_idx;
    logic          found;

    // Scan from r_ptr upward, wrapping, and take the first valid requester.
    always_comb begin
        idx     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            idx = PW'((int'(r_ptr) + off) % NREQ);
            if (!found && iw_valid[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        if (!iw_rst_n) begin
            found = 1'b0;
        end
        ow_grant = found ? (NREQ'(1) << gnt_idx) : '0;
    end

    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            r_ptr <= '0;
        end else if (found) begin
            r_ptr <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/arwb_sched.sv
// rtl/arwb_sched.sv - shares the regar write port among writeback sources and tracks pending ARs
module arwb_sched
    import arwb_sched_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic                        iw_clk,
    input  logic                        iw_rst_n,
    input  logic [NREQ-1:0]             iw_req_valid,
    input  logic [NREQ*SIZE_TGT_GP-1:0] iw_req_addr,
    input  logic [NREQ*SIZE_ADDR-1:0]   iw_req_data,
    output logic [NREQ-1:0]             ow_req_ready,
    input  logic                        iw_rsv_valid,
    input  logic [HBIT_TGT_GP:0]        iw_rsv_addr,
    output logic                        ow_write_enable,
    output logic [HBIT_TGT_GP:0]        ow_write_addr,
    output logic [HBIT_ADDR:0]          ow_write_data,
    output logic [HBIT_AR:0]            ow_pending
);

    logic [NREQ-1:0]      grant;
    logic [HBIT_TGT_GP:0] sel_addr;
    logic [HBIT_ADDR:0]   sel_data;
    logic [HBIT_AR:0]     set_mask;
    logic [HBIT_AR:0]     clr_mask;

    arwb_sched_rr_arb #(.NREQ(NREQ)) u_arb (
        .iw_clk   (iw_clk),
        .iw_rst_n (iw_rst_n),
        .iw_valid (iw_req_valid),
        .ow_grant (grant)
    );

    assign ow_req_ready = grant;

    // Grant is one-hot, so an OR of the gated slices is the mux.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = sel_addr | iw_req_addr[i*SIZE_TGT_GP +: SIZE_TGT_GP];
                sel_data = sel_data | iw_req_data[i*SIZE_ADDR +: SIZE_ADDR];
            end
        end
    end

    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            ow_write_enable <= 1'b0;
            ow_write_addr   <= '0;
            ow_write_data   <= '0;
        end else begin
            ow_write_enable <= |grant;
            if (|grant) begin
                ow_write_addr <= sel_addr;
                ow_write_data <= sel_data;
            end
        end
    end

    always_comb begin
        set_mask = iw_rsv_valid ? ar_onehot(iw_rsv_addr) : '0;
        clr_mask = ow_write_enable ? ar_onehot(ow_write_addr) : '0;
    end

    // Set is applied after clear so a reservation racing a completing write survives.
    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            ow_pending <= '0;
        end else begin
            ow_pending <= (ow_pending & ~clr_mask) | set_mask;
        end
    end

endmodule
